// File: rtl/tinker_mem_pkg.sv
// rtl/tinker_mem_pkg.sv - shared types and widths for the memory port arbiter
package tinker_mem_pkg;
   localparam int INSTR_W = 32;
   localparam int DATA_W  = 64;

   typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_e;
   typedef enum logic [1:0] {GNT_NONE, GNT_IF, GNT_D} grant_e;
endpackage

// File: rtl/arb_prio_starve.sv
// rtl/arb_prio_starve.sv - data-first priority select with fetch starvation guard
module arb_prio_starve
   import tinker_mem_pkg::*;
#(
   parameter int STARVE_MAX = 4
) (
   input  logic   clk,
   input  logic   reset,
   input  logic   if_valid,
   input  logic   d_valid,
   input  logic   grant_en,
   output grant_e grant
);
   localparam int CW = $clog2(STARVE_MAX + 1);
   localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

   logic [CW-1:0] starve_q, starve_d;

   always_comb begin
      grant    = GNT_NONE;
      starve_d = starve_q;
      if (grant_en) begin
         if (if_valid && (!d_valid || starve_q == STARVE_LIM)) begin
            grant = GNT_IF;
         end else if (d_valid) begin
            grant = GNT_D;
         end
      end
      if (grant == GNT_IF) begin
         starve_d = '0;
      end else if (grant == GNT_D && if_valid && starve_q != STARVE_LIM) begin
         starve_d = starve_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         starve_q <= '0;
      end else begin
         starve_q <= starve_d;
      end
   end
endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter for the shared byte memory
// Optional MEM_PORT_ARBITER_PERF_EN adds saturating grant and stall counters.
module mem_port_arbiter
   import tinker_mem_pkg::*;
#(
   parameter int ADDR_W     = 64,
   parameter int MEM_LAT    = 1,
   parameter int STARVE_MAX = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               if_req_valid,
   input  logic [ADDR_W-1:0]  if_req_addr,
   output logic               if_req_ready,
   output logic               if_rsp_valid,
   output logic [INSTR_W-1:0] if_rsp_instr,
   input  logic               d_req_valid,
   input  logic               d_req_we,
   input  logic [ADDR_W-1:0]  d_req_addr,
   input  logic [DATA_W-1:0]  d_req_wdata,
   output logic               d_req_ready,
   output logic               d_rsp_valid,
   output logic [DATA_W-1:0]  d_rsp_data,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic               mem_read_instr,
   output logic               mem_read_data,
   output logic               mem_write,
   output logic [DATA_W-1:0]  mem_write_data,
   input  logic [INSTR_W-1:0] mem_instr_in,
   input  logic [DATA_W-1:0]  mem_data_in
`ifdef MEM_PORT_ARBITER_PERF_EN
  ,output logic [31:0]        perf_if_grants,
   output logic [31:0]        perf_d_grants,
   output logic [31:0]        perf_stall_cycles
`endif
);
   localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(MEM_LAT - 1);

   state_e             state_q, state_d;
   grant_e             gnt_q, gnt_d, grant;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic               we_q, we_d;
   logic [DATA_W-1:0]  wdata_q, wdata_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [INSTR_W-1:0] instr_q, instr_d;
   logic [DATA_W-1:0]  data_q, data_d;
   logic               grant_en, in_access, in_resp, is_if, is_d;

   // Reset gates the grant so ready stays low while reset is held.
   assign grant_en = (state_q == ST_IDLE) && !reset;

   arb_prio_starve #(.STARVE_MAX(STARVE_MAX)) u_arb (
      .clk      (clk),
      .reset    (reset),
      .if_valid (if_req_valid),
      .d_valid  (d_req_valid),
      .grant_en (grant_en),
      .grant    (grant)
   );

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      addr_d  = addr_q;
      we_d    = we_q;
      wdata_d = wdata_q;
      cnt_d   = cnt_q;
      instr_d = instr_q;
      data_d  = data_q;
      case (state_q)
         ST_IDLE: begin
            if (grant != GNT_NONE) begin
               state_d = ST_ACCESS;
               gnt_d   = grant;
               cnt_d   = LAT_LAST;
               if (grant == GNT_IF) begin
                  addr_d  = if_req_addr;
                  we_d    = 1'b0;
                  wdata_d = '0;
               end else begin
                  addr_d  = d_req_addr;
                  we_d    = d_req_we;
                  wdata_d = d_req_wdata;
               end
            end
         end
         ST_ACCESS: begin
            if (cnt_q == '0) begin
               state_d = ST_RESP;
               instr_d = mem_instr_in;
               data_d  = we_q ? '0 : mem_data_in;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         gnt_q   <= GNT_NONE;
         addr_q  <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
         cnt_q   <= '0;
         instr_q <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         wdata_q <= wdata_d;
         cnt_q   <= cnt_d;
         instr_q <= instr_d;
         data_q  <= data_d;
      end
   end

   assign in_access = (state_q == ST_ACCESS);
   assign in_resp   = (state_q == ST_RESP);
   assign is_if     = (gnt_q == GNT_IF);
   assign is_d      = (gnt_q == GNT_D);

   assign if_req_ready   = (grant == GNT_IF);
   assign d_req_ready    = (grant == GNT_D);
   assign mem_addr       = addr_q;
   assign mem_read_instr = in_access && is_if;
   assign mem_read_data  = in_access && is_d && !we_q;
   // Strobe only on the first ACCESS cycle so each store writes exactly once.
   assign mem_write      = in_access && is_d && we_q && (cnt_q == LAT_LAST);
   assign mem_write_data = (in_access && is_d && we_q) ? wdata_q : '0;
   assign if_rsp_valid   = in_resp && is_if;
   assign if_rsp_instr   = if_rsp_valid ? instr_q : '0;
   assign d_rsp_valid    = in_resp && is_d;
   assign d_rsp_data     = d_rsp_valid ? data_q : '0;

`ifdef MEM_PORT_ARBITER_PERF_EN
   logic [31:0] pif_q, pif_d, pd_q, pd_d, pst_q, pst_d;
   logic        stall;

   assign stall = (if_req_valid && !if_req_ready) || (d_req_valid && !d_req_ready);

   always_comb begin
      pif_d = pif_q;
      pd_d  = pd_q;
      pst_d = pst_q;
      if (if_req_ready && pif_q != '1) pif_d = pif_q + 1'b1;
      if (d_req_ready && pd_q != '1)   pd_d  = pd_q + 1'b1;
      if (stall && pst_q != '1)        pst_d = pst_q + 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pif_q <= '0;
         pd_q  <= '0;
         pst_q <= '0;
      end else begin
         pif_q <= pif_d;
         pd_q  <= pd_d;
         pst_q <= pst_d;
      end
   end

   assign perf_if_grants    = pif_q;
   assign perf_d_grants     = pd_q;
   assign perf_stall_cycles = pst_q;
`endif
endmodule
